clz_norm_arb: RTL and testbench
===============================

Name: clz_norm_arb

Overview:
- Shares one combinational `clz` instance (32-bit in `a`, 32-bit count out `n`, count 32 for zero input) between two requesters, e.g. the ALU and a normalising datapath.
- Per accepted operand it sequences count-then-shift and returns three results: the left-normalised value, the leading-zero count, and a zero flag.
- Uses a valid/ready handshake on both the request and response sides.

Parameters:
- REQ_FAIR, 1: 1 = round-robin arbitration between req0/req1; 0 = fixed priority, req0 always wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand.
- req0_data  input  32  requester 0 operand.
- req0_ready  output  1  requester 0 operand accepted this cycle when req0_valid also high.
- req1_valid  input  1  requester 1 has an operand.
- req1_data  input  32  requester 1 operand.
- req1_ready  output  1  requester 1 operand accepted this cycle when req1_valid also high.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_id  output  1  requester that issued the result (0/1).
- resp_norm  output  32  operand shifted left by resp_count; 0 for zero operand.
- resp_count  output  6  leading zeros, 0..32.
- resp_zero  output  1  operand was 0.
- busy  output  1  high in any state other than IDLE.
- stat0_cnt  output  16  completed ops, requester 0 (see optional feature).
- stat1_cnt  output  16  completed ops, requester 1 (see optional feature).

Behaviour:
- Reset values: state IDLE; all outputs 0 except req0_ready, which follows the IDLE grant rule below. Round-robin pointer favours req0. Operand, count and norm registers are 0.
- FSM states: IDLE -> COUNT -> SHIFT -> DONE -> IDLE.
- IDLE, grant rule:
  - reqX_ready = (state==IDLE) & grantX; ready is combinational from both valids.
  - grant0 = req0_valid & (!req1_valid | ptr==0); grant1 = req1_valid & (!req0_valid | ptr==1).
  - With REQ_FAIR=0: grant0 = req0_valid; grant1 = req1_valid & !req0_valid.
  - At most one ready is high per cycle. ready is never high outside IDLE.
- IDLE, on accept (valid & ready at edge):
  - latch the granted operand and requester id;
  - set ptr to the other requester;
  - go to COUNT.
- COUNT: drive the operand into `clz`; register n[5:0] into the count register; go to SHIFT.
- SHIFT:
  - norm = (count==32) ? 0 : operand << count;
  - zero flag = (count==32);
  - go to DONE.
  - The shift amount used is the registered count only, never a combinational path from `clz`.
- DONE:
  - resp_valid=1; resp_id, resp_norm, resp_count and resp_zero are held stable until resp_ready.
  - On resp_valid & resp_ready at an edge: go to IDLE, resp_valid drops next cycle.
- Latency: accept edge T -> resp_valid high in cycle T+3.
- Throughput: with resp_ready tied high, one operand per 4 cycles. A new operand is accepted in the first IDLE cycle after the response handshake.
- Response outputs are meaningful only while resp_valid=1. They keep their last values otherwise and are not required to be 0.
- Reset asserted in any state, including mid-operation: the next cycle is IDLE, resp_valid=0, busy=0, in-flight operand discarded, ptr favours req0. Stat counters are cleared.
- No back-pressure from requesters is needed: if a requester drops valid before being granted, nothing is latched.

Optional Feature:
- Macro: CLZ_NORM_STATS_EN
- Defined:
  - stat0_cnt/stat1_cnt count completed response handshakes per resp_id.
  - 16-bit, saturating at 0xFFFF.
  - Cleared by reset.
- Undefined: ports still exist and are tied to 0; no counter logic is synthesised.

Test Plan:
1. req0_valid=1, req0_data=0x00010000, resp_ready=1 -> req0_ready=1 in the accept cycle; resp_valid exactly 3 cycles later with resp_count=15, resp_norm=0x80000000, resp_zero=0, resp_id=0.
2. req1 data sweep with resp_ready=1:
   - 0x00000000 -> count=32, norm=0, zero=1, id=1;
   - 0x80000000 -> count=0, norm=0x80000000;
   - 0x00000001 -> count=31, norm=0x80000000.
3. REQ_FAIR=1, both valids held high for 4 ops (data 0x1 / 0x2) -> accept order is 0,1,0,1 with resp_id matching. Repeat with REQ_FAIR=0 -> all four go to req0, req1_ready never high.
4. resp_ready low for 5 cycles in DONE -> resp_valid and all resp fields stable, both readys 0, busy=1. Raise resp_ready -> handshake, then IDLE, then next operand accepted the following cycle.
5. reset pulsed for 1 cycle while in SHIFT (operand 0x00F00000) -> next cycle resp_valid=0, busy=0, req0_ready=1 if req0_valid. The next op (0x0000FFFF) returns count=16 correctly.
6. With CLZ_NORM_STATS_EN, 3 req0 + 2 req1 completions -> stat0_cnt=3, stat1_cnt=2; after reset both 0. Without the macro both stay 0.

Source files
------------

// File: rtl/clz_norm_arb.sv
// Two-requester arbiter around one shared leading-zero counter; returns count, normalised value
// and zero flag per operand. Optional CLZ_NORM_STATS_EN adds per-requester completion counters.
module clz_norm_arb #(
    parameter int unsigned REQ_FAIR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_norm,
    output logic [5:0]  resp_count,
    output logic        resp_zero,
    output logic        busy,
    output logic [15:0] stat0_cnt,
    output logic [15:0] stat1_cnt
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCount = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [31:0] operand_q, operand_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] norm_q, norm_d;
    logic        zero_q, zero_d;

    logic        grant0, grant1;
    logic [31:0] clz_a;
    logic [5:0]  clz_n;

    always_comb begin
        if (REQ_FAIR != 0) begin
            grant0 = req0_valid & (~req1_valid | ~ptr_q);
            grant1 = req1_valid & (~req0_valid | ptr_q);
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
        end
    end

    assign req0_ready = (state_q == StIdle) & grant0;
    assign req1_ready = (state_q == StIdle) & grant1;

    // Shared counter: always fed from the latched operand, sampled only in COUNT.
    assign clz_a = operand_q;

    always_comb begin
        clz_n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (clz_a[i]) begin
                clz_n = 6'(31 - i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        operand_d = operand_q;
        count_d   = count_q;
        norm_d    = norm_q;
        zero_d    = zero_q;
        case (state_q)
            StIdle: begin
                if (req0_ready) begin
                    operand_d = req0_data;
                    id_d      = 1'b0;
                    ptr_d     = 1'b1;
                    state_d   = StCount;
                end else if (req1_ready) begin
                    operand_d = req1_data;
                    id_d      = 1'b1;
                    ptr_d     = 1'b0;
                    state_d   = StCount;
                end
            end
            StCount: begin
                count_d = clz_n;
                state_d = StShift;
            end
            StShift: begin
                // Shift by the registered count so clz is never in series with the shifter.
                zero_d  = (count_q == 6'd32);
                norm_d  = (count_q == 6'd32) ? 32'd0 : (operand_q << count_q);
                state_d = StDone;
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            operand_q <= 32'd0;
            count_q   <= 6'd0;
            norm_q    <= 32'd0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            operand_q <= operand_d;
            count_q   <= count_d;
            norm_q    <= norm_d;
            zero_q    <= zero_d;
        end
    end

    assign resp_valid = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign resp_id    = id_q;
    assign resp_norm  = norm_q;
    assign resp_count = count_q;
    assign resp_zero  = zero_q;

`ifdef CLZ_NORM_STATS_EN
    logic [15:0] stat0_q, stat1_q;
    logic        resp_fire;

    assign resp_fire = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat0_q <= 16'd0;
            stat1_q <= 16'd0;
        end else if (resp_fire) begin
            if (!id_q && stat0_q != 16'hFFFF) begin
                stat0_q <= stat0_q + 16'd1;
            end
            if (id_q && stat1_q != 16'hFFFF) begin
                stat1_q <= stat1_q + 16'd1;
            end
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`else
    assign stat0_cnt = 16'd0;
    assign stat1_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clz_norm_arb.sv
// Self-checking bench for clz_norm_arb: vector table, hand-written corner sequences and a
// randomised run against a shift-loop reference model. A fixed-priority copy shares the inputs.
module tb_clz_norm_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, resp_ready;
    logic [31:0] req0_data, req1_data;

    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_zero, busy;
    logic [31:0] resp_norm;
    logic [5:0]  resp_count;
    logic [15:0] stat0_cnt, stat1_cnt;

    logic        b_req0_ready, b_req1_ready, b_resp_valid, b_resp_id, b_resp_zero, b_busy;
    logic [31:0] b_resp_norm;
    logic [5:0]  b_resp_count;
    logic [15:0] b_stat0_cnt, b_stat1_cnt;

    clz_norm_arb #(.REQ_FAIR(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_norm(resp_norm), .resp_count(resp_count), .resp_zero(resp_zero),
        .busy(busy), .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
    );

    clz_norm_arb #(.REQ_FAIR(0)) dut_fix (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_req1_ready),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_id(b_resp_id),
        .resp_norm(b_resp_norm), .resp_count(b_resp_count), .resp_zero(b_resp_zero),
        .busy(b_busy), .stat0_cnt(b_stat0_cnt), .stat1_cnt(b_stat1_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   sc0 = 0;
    int   sc1 = 0;
    logic ptr = 1'b0;
    logic mon_en = 1'b0;
    int   b1_seen = 0;

    always @(negedge clk) begin
        if (mon_en && b_req1_ready) b1_seen++;
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [5:0]  count;
        logic [31:0] norm;
        logic        zero;
    } vec_t;

    vec_t tbl[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Normalise by repeated doubling until the MSB is set.
    task automatic ref_clz(input logic [31:0] x, output logic [5:0] cnt, output logic [31:0] norm);
        logic [31:0] v;
        int c;
        v = x;
        c = 0;
        while (c < 32 && v[31] == 1'b0) begin
            v = v << 1;
            c++;
        end
        cnt  = 6'(c);
        norm = v;
    endtask

    function automatic logic [15:0] stat_exp(input int n);
`ifdef CLZ_NORM_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'd0;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ptr = 1'b0;
        sc0 = 0;
        sc1 = 0;
    endtask

    task automatic wait_resp();
        int lat;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
    endtask

    // One complete transaction from IDLE; g is the requester the bench expects to win.
    task automatic run_op(input logic v0, input logic v1, input logic [31:0] d0,
                          input logic [31:0] d1, input logic g, input int stall,
                          input logic [5:0] ecnt, input logic [31:0] enorm, input logic ezero);
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = d0;
        req1_data  = d1;
        resp_ready = 1'b0;
        #1;
        chk("req0_ready", 32'(req0_ready), 32'(g == 1'b0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1'b1));
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp();
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", 32'(resp_valid), 32'd1);
        end
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("resp_count", 32'(resp_count), 32'(ecnt));
        chk("resp_norm", resp_norm, enorm);
        chk("resp_zero", 32'(resp_zero), 32'(ezero));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        ptr = ~g;
        if (g) sc1++;
        else sc0++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ecnt;
        logic [31:0] enorm, d0, d1;
        logic        v0, v1, g;

        tbl[0] = '{id: 1'b0, data: 32'h0001_0000, count: 6'd15, norm: 32'h8000_0000, zero: 1'b0};
        tbl[1] = '{id: 1'b1, data: 32'h0000_0000, count: 6'd32, norm: 32'h0000_0000, zero: 1'b1};
        tbl[2] = '{id: 1'b1, data: 32'h8000_0000, count: 6'd0,  norm: 32'h8000_0000, zero: 1'b0};
        tbl[3] = '{id: 1'b1, data: 32'h0000_0001, count: 6'd31, norm: 32'h8000_0000, zero: 1'b0};

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 32'd0;
        req1_data  = 32'd0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        step();
        do_reset();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_count", 32'(resp_count), 32'd0);
        chk("rst_norm", resp_norm, 32'd0);
        chk("rst_stat0", 32'(stat0_cnt), 32'd0);
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0_valid", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_op(~tbl[i].id, tbl[i].id, tbl[i].data, tbl[i].data, tbl[i].id, 0,
                   tbl[i].count, tbl[i].norm, tbl[i].zero);
        end

        // Stall in DONE with both requesters waiting.
        req0_valid = 1'b1;
        req0_data  = 32'h0000_1234;
        #1;
        step();
        req1_valid = 1'b1;
        req1_data  = 32'h0000_0100;
        step();
        step();
        for (int s = 0; s < 5; s++) begin
            chk("st_valid", 32'(resp_valid), 32'd1);
            chk("st_busy", 32'(busy), 32'd1);
            chk("st_ready0", 32'(req0_ready), 32'd0);
            chk("st_ready1", 32'(req1_ready), 32'd0);
            chk("st_id", 32'(resp_id), 32'd0);
            chk("st_count", 32'(resp_count), 32'd19);
            chk("st_norm", resp_norm, 32'h91A0_0000);
            chk("st_zero", 32'(resp_zero), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("st_idle_valid", 32'(resp_valid), 32'd0);
        chk("st_idle_busy", 32'(busy), 32'd0);
        chk("st_idle_ready1", 32'(req1_ready), 32'd1);
        chk("st_idle_ready0", 32'(req0_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("st_accept_busy", 32'(busy), 32'd1);
        wait_resp();
        chk("st2_id", 32'(resp_id), 32'd1);
        chk("st2_count", 32'(resp_count), 32'd23);
        chk("st2_norm", resp_norm, 32'h8000_0000);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        sc0++;
        sc1++;
        ptr = 1'b0;

        // Both requesters held: round-robin alternates, fixed priority copy serves only req0.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'h1;
        req1_valid = 1'b1;
        req1_data  = 32'h2;
        resp_ready = 1'b1;
        mon_en     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            chk("rr_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            chk("fix_ready0", 32'(b_req0_ready), 32'd1);
            step();
            step();
            step();
            chk("rr_valid", 32'(resp_valid), 32'd1);
            chk("rr_id", 32'(resp_id), 32'(k % 2));
            chk("rr_count", 32'(resp_count), (k % 2 == 0) ? 32'd31 : 32'd30);
            chk("fix_id", 32'(b_resp_id), 32'd0);
            chk("fix_count", 32'(b_resp_count), 32'd31);
            step();
        end
        mon_en     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        chk("fix_ready1_seen", 32'(b1_seen), 32'd0);
        sc0 = 2;
        sc1 = 2;
        ptr = 1'b0;

        // Reset pulsed while in SHIFT discards the operand.
        req0_valid = 1'b1;
        req0_data  = 32'h00F0_0000;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        req0_valid = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready0", 32'(req0_ready), 32'd1);
        chk("mid_rst_count", 32'(resp_count), 32'd0);
        chk("mid_rst_stat0", 32'(stat0_cnt), 32'd0);
        req0_valid = 1'b0;
        run_op(1'b1, 1'b0, 32'h0000_FFFF, 32'd0, 1'b0, 0, 6'd16, 32'hFFFF_0000, 1'b0);

        // Completion counters: 3 req0 and 2 req1 since the last reset.
        run_op(1'b1, 1'b0, 32'h0000_0003, 32'd0, 1'b0, 1, 6'd30, 32'hC000_0000, 1'b0);
        run_op(1'b0, 1'b1, 32'd0, 32'h0800_0000, 1'b1, 0, 6'd4, 32'h8000_0000, 1'b0);
        run_op(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 2, 6'd32, 32'h0000_0000, 1'b1);
        run_op(1'b0, 1'b1, 32'd0, 32'h0000_0005, 1'b1, 0, 6'd29, 32'hA000_0000, 1'b0);
        chk("stat0", 32'(stat0_cnt), 32'(stat_exp(3)));
        chk("stat1", 32'(stat1_cnt), 32'(stat_exp(2)));
        do_reset();
        chk("stat0_rst", 32'(stat0_cnt), 32'd0);
        chk("stat1_rst", 32'(stat1_cnt), 32'd0);

        for (int k = 0; k < 30; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            d0 = $urandom;
            d0 = d0 >> $urandom_range(0, 32);
            d1 = $urandom;
            d1 = d1 >> $urandom_range(0, 32);
            g = (v0 && v1) ? ptr : v1;
            ref_clz(g ? d1 : d0, ecnt, enorm);
            run_op(v0, v1, d0, d1, g, int'($urandom_range(0, 3)), ecnt, enorm, ecnt == 6'd32);
        end
        chk("stat0_rand", 32'(stat0_cnt), 32'(stat_exp(sc0)));
        chk("stat1_rand", 32'(stat1_cnt), 32'(stat_exp(sc1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
